// File: rtl/scr1_brkm_bp_ctrl_pkg.sv
// Shared types and constants for the BRKM breakpoint controller: register select,
// CTRL bit positions, FSM states and hit-count width (COUNT exists only with SCR1_BRKM_HITCNT_EN).
package scr1_brkm_bp_ctrl_pkg;

    typedef enum logic [1:0] {
        SCR1_BRKM_REG_CTRL  = 2'd0,
        SCR1_BRKM_REG_LO    = 2'd1,
        SCR1_BRKM_REG_HI    = 2'd2,
        SCR1_BRKM_REG_COUNT = 2'd3
    } type_scr1_brkm_reg_e;

    localparam int SCR1_BRKM_CTRL_EXACT_EN    = 0;
    localparam int SCR1_BRKM_CTRL_MASK_EN     = 1;
    localparam int SCR1_BRKM_CTRL_MASK_EXT_EN = 2;
    localparam int SCR1_BRKM_CTRL_ACTION      = 3;
    localparam int SCR1_BRKM_CTRL_ARMED       = 4;
    localparam int SCR1_BRKM_CTRL_ONESHOT     = 5;
    localparam int SCR1_BRKM_CTRL_HIT         = 8;

    typedef enum logic {
        SCR1_BRKM_FSM_IDLE = 1'b0,
        SCR1_BRKM_FSM_REQ  = 1'b1
    } type_scr1_brkm_fsm_e;

    localparam int SCR1_BRKM_HITCNT_W = 16;

endpackage

// File: rtl/scr1_brkm_bp_ctrl_if.sv
// CSR access and breakpoint request/ack bundle; master is the CSR/pipeline side,
// slave is the breakpoint controller.
interface scr1_brkm_bp_ctrl_if #(
    parameter int BP_IDX_W = 1
);
    logic                csr_req;
    logic                csr_we;
    logic [BP_IDX_W-1:0] csr_bp;
    logic [1:0]          csr_reg;
    logic [31:0]         csr_wdata;
    logic [31:0]         csr_rdata;
    logic                brk_req;
    logic [BP_IDX_W-1:0] brk_bp;
    logic                brk_action;
    logic                brk_ack;

    modport master (
        output csr_req, csr_we, csr_bp, csr_reg, csr_wdata, brk_ack,
        input  csr_rdata, brk_req, brk_bp, brk_action
    );

    modport slave (
        input  csr_req, csr_we, csr_bp, csr_reg, csr_wdata, brk_ack,
        output csr_rdata, brk_req, brk_bp, brk_action
    );
endinterface

// File: rtl/scr1_brkm_bp_regs.sv
// One breakpoint's register slice: CTRL, LO, HI and (with SCR1_BRKM_HITCNT_EN) COUNT.
// CSR writes take priority over hardware updates, except hit where set beats W1C.
module scr1_brkm_bp_regs
    import scr1_brkm_bp_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_ctrl_i,
    input  logic                          wr_lo_i,
    input  logic                          wr_hi_i,
    input  logic                          wr_cnt_i,
    input  logic [31:0]                   wdata_i,
    input  logic                          fire_i,
    input  logic                          dec_i,
    output logic [31:0]                   ctrl_o,
    output logic [AW-1:0]                 lo_o,
    output logic [AW-1:0]                 hi_o,
    output logic [SCR1_BRKM_HITCNT_W-1:0] cnt_o,
    output logic                          armed_o,
    output logic                          action_o,
    output logic                          exact_en_o,
    output logic                          mask_en_o,
    output logic                          mask_ext_en_o
);
    logic          exact_q, mask_q, mask_ext_q, action_q, armed_q, oneshot_q, hit_q;
    logic          armed_d, hit_d;
    logic [AW-1:0] lo_q, hi_q;
    logic          unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        armed_d = armed_q;
        if (wr_ctrl_i) begin
            armed_d = wdata_i[SCR1_BRKM_CTRL_ARMED];
        end else if (fire_i && oneshot_q) begin
            armed_d = 1'b0;
        end
        hit_d = (hit_q & ~(wr_ctrl_i & wdata_i[SCR1_BRKM_CTRL_HIT])) | fire_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact_q    <= 1'b0;
            mask_q     <= 1'b0;
            mask_ext_q <= 1'b0;
            action_q   <= 1'b0;
            armed_q    <= 1'b0;
            oneshot_q  <= 1'b0;
            hit_q      <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            if (wr_ctrl_i) begin
                exact_q    <= wdata_i[SCR1_BRKM_CTRL_EXACT_EN];
                mask_q     <= wdata_i[SCR1_BRKM_CTRL_MASK_EN];
                mask_ext_q <= wdata_i[SCR1_BRKM_CTRL_MASK_EXT_EN];
                action_q   <= wdata_i[SCR1_BRKM_CTRL_ACTION];
                oneshot_q  <= wdata_i[SCR1_BRKM_CTRL_ONESHOT];
            end
            armed_q <= armed_d;
            hit_q   <= hit_d;
            if (wr_lo_i) lo_q <= wdata_i[AW-1:0];
            if (wr_hi_i) hi_q <= wdata_i[AW-1:0];
        end
    end

`ifdef SCR1_BRKM_HITCNT_EN
    logic [SCR1_BRKM_HITCNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wr_cnt_i) begin
            cnt_q <= wdata_i[SCR1_BRKM_HITCNT_W-1:0];
        end else if (dec_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
    assign cnt_o = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = wr_cnt_i ^ dec_i;
    assign cnt_o      = '0;
`endif

    always_comb begin
        ctrl_o                             = '0;
        ctrl_o[SCR1_BRKM_CTRL_EXACT_EN]    = exact_q;
        ctrl_o[SCR1_BRKM_CTRL_MASK_EN]     = mask_q;
        ctrl_o[SCR1_BRKM_CTRL_MASK_EXT_EN] = mask_ext_q;
        ctrl_o[SCR1_BRKM_CTRL_ACTION]      = action_q;
        ctrl_o[SCR1_BRKM_CTRL_ARMED]       = armed_q;
        ctrl_o[SCR1_BRKM_CTRL_ONESHOT]     = oneshot_q;
        ctrl_o[SCR1_BRKM_CTRL_HIT]         = hit_q;
    end

    assign lo_o          = lo_q;
    assign hi_o          = hi_q;
    assign armed_o       = armed_q;
    assign action_o      = action_q;
    assign exact_en_o    = exact_q & armed_q;
    assign mask_en_o     = mask_q & armed_q;
    assign mask_ext_en_o = mask_ext_q & armed_q;

endmodule

// File: rtl/scr1_brkm_bp_ctrl.sv
// BRKM breakpoint controller: per-breakpoint register slices, CSR decode/readback,
// lowest-index priority select and IDLE/REQ request FSM. Hit count needs SCR1_BRKM_HITCNT_EN.
module scr1_brkm_bp_ctrl
    import scr1_brkm_bp_ctrl_pkg::*;
#(
    parameter int BRKM_BP_NUM           = 2,
    parameter int BRKM_MATCH_ADDR_WIDTH = 32,
    parameter int BRKM_BP_IDX_W         = (BRKM_BP_NUM > 1) ? $clog2(BRKM_BP_NUM) : 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    scr1_brkm_bp_ctrl_if.slave                                  bus,
    output logic [BRKM_BP_NUM-1:0]                              bp_exact_en_o,
    output logic [BRKM_BP_NUM-1:0]                              bp_mask_en_o,
    output logic [BRKM_BP_NUM-1:0]                              bp_mask_ext_en_o,
    output logic [BRKM_BP_NUM-1:0][BRKM_MATCH_ADDR_WIDTH-1:0]  bp_addr_lo_o,
    output logic [BRKM_BP_NUM-1:0][BRKM_MATCH_ADDR_WIDTH-1:0]  bp_addr_hi_o,
    input  logic [BRKM_BP_NUM-1:0]                              bp_match_i
);
    type_scr1_brkm_fsm_e             state_q, state_d;
    logic [BRKM_BP_IDX_W-1:0]        brk_bp_q, brk_bp_d;
    logic                            brk_action_q, brk_action_d;

    logic [31:0]                     ctrl_rd [BRKM_BP_NUM];
    logic [SCR1_BRKM_HITCNT_W-1:0]   cnt_rd  [BRKM_BP_NUM];
    logic [BRKM_BP_NUM-1:0]          armed_vec, action_vec, fire_vec, dec_vec;
    logic                            bp_in_range, csr_wr;
    logic                            sel_found;
    logic [BRKM_BP_IDX_W-1:0]        sel_idx;
    logic [31:0]                     rdata;

    assign bp_in_range = int'(bus.csr_bp) < BRKM_BP_NUM;
    assign csr_wr      = bus.csr_req & bus.csr_we & bp_in_range;

    generate
        for (genvar gi = 0; gi < BRKM_BP_NUM; gi++) begin : g_bp
            logic wr_sel;
            assign wr_sel = csr_wr && (int'(bus.csr_bp) == gi);

            scr1_brkm_bp_regs #(.AW(BRKM_MATCH_ADDR_WIDTH)) u_regs (
                .clk           (clk),
                .rst           (rst),
                .wr_ctrl_i     (wr_sel && (bus.csr_reg == SCR1_BRKM_REG_CTRL)),
                .wr_lo_i       (wr_sel && (bus.csr_reg == SCR1_BRKM_REG_LO)),
                .wr_hi_i       (wr_sel && (bus.csr_reg == SCR1_BRKM_REG_HI)),
                .wr_cnt_i      (wr_sel && (bus.csr_reg == SCR1_BRKM_REG_COUNT)),
                .wdata_i       (bus.csr_wdata),
                .fire_i        (fire_vec[gi]),
                .dec_i         (dec_vec[gi]),
                .ctrl_o        (ctrl_rd[gi]),
                .lo_o          (bp_addr_lo_o[gi]),
                .hi_o          (bp_addr_hi_o[gi]),
                .cnt_o         (cnt_rd[gi]),
                .armed_o       (armed_vec[gi]),
                .action_o      (action_vec[gi]),
                .exact_en_o    (bp_exact_en_o[gi]),
                .mask_en_o     (bp_mask_en_o[gi]),
                .mask_ext_en_o (bp_mask_ext_en_o[gi])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (bp_in_range) begin
            case (type_scr1_brkm_reg_e'(bus.csr_reg))
                SCR1_BRKM_REG_CTRL:  rdata = ctrl_rd[bus.csr_bp];
                SCR1_BRKM_REG_LO:    rdata = 32'(bp_addr_lo_o[bus.csr_bp]);
                SCR1_BRKM_REG_HI:    rdata = 32'(bp_addr_hi_o[bus.csr_bp]);
                SCR1_BRKM_REG_COUNT: rdata = 32'(cnt_rd[bus.csr_bp]);
                default:             rdata = '0;
            endcase
        end
    end
    assign bus.csr_rdata = rdata;

    // Descending scan so the lowest armed matching index ends up selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = BRKM_BP_NUM - 1; i >= 0; i--) begin
            if (bp_match_i[i] && armed_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = BRKM_BP_IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        brk_bp_d     = brk_bp_q;
        brk_action_d = brk_action_q;
        fire_vec     = '0;
        dec_vec      = '0;
        case (state_q)
            SCR1_BRKM_FSM_IDLE: begin
                if (sel_found) begin
                    if (cnt_rd[sel_idx] != '0) begin
                        dec_vec[sel_idx] = 1'b1;
                    end else begin
                        fire_vec[sel_idx] = 1'b1;
                        brk_bp_d          = sel_idx;
                        brk_action_d      = action_vec[sel_idx];
                        state_d           = SCR1_BRKM_FSM_REQ;
                    end
                end
            end
            SCR1_BRKM_FSM_REQ: begin
                if (bus.brk_ack) state_d = SCR1_BRKM_FSM_IDLE;
            end
            default: state_d = SCR1_BRKM_FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SCR1_BRKM_FSM_IDLE;
            brk_bp_q     <= '0;
            brk_action_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            brk_bp_q     <= brk_bp_d;
            brk_action_q <= brk_action_d;
        end
    end

    assign bus.brk_req    = (state_q == SCR1_BRKM_FSM_REQ);
    assign bus.brk_bp     = brk_bp_q;
    assign bus.brk_action = brk_action_q;

endmodule
